// File: rtl/spi_storage_responder.sv
// ---------------------------------------------------------------------------
// spi_storage_responder
// On-chip stand-in for the external SPI storage part. The SCK/SCS/MOSI
// inputs are oversampled on clk, a byte command set (read 0x03, write 0x02,
// optionally write-enable 0x06) is decoded, and a 2^MEM_AW byte memory is
// served.
//
// Optional feature: define STORAGE_WEL_EN to require a prior 0x06
// (write-enable latch) before a 0x02 write transfers any data.
//
// Ports:
//   clk       system clock
//   rstn      asynchronous active-low reset
//   spiSCK    SPI clock from initiator (mode 0, idles low)
//   spiSCS    SPI chip select, active low
//   spiMOSI   serial data in, MSB first
//   spiMISO   serial data out, MSB first (0 outside read data phase)
//   selected  synchronized active-high chip select
//   wrStrobe  one-clk pulse per byte committed to memory
// ---------------------------------------------------------------------------
module spi_storage_responder #(
    parameter int MEM_AW = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic spiSCK,
    input  logic spiSCS,
    input  logic spiMOSI,
    output logic spiMISO,
    output logic selected,
    output logic wrStrobe
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, IGNORE} state_t;

    localparam logic [15:0] AMASK = 16'((32'd1 << MEM_AW) - 32'd1);

    state_t      state;
    logic        sck_s1, sck_s2, sck_d;
    logic        cs_s1, cs_s2, cs_d;
    logic        mosi_s1, mosi_s2;
    logic [4:0]  bit_cnt;
    logic [15:0] addr;
    logic [7:0]  rx;
    logic [7:0]  tx;
    logic [1:0]  ld_pipe;   // memory read latency: address settle, then tx load
    logic        is_wr;
`ifdef STORAGE_WEL_EN
    logic        wel;
`endif

    logic [7:0]  mem [2**MEM_AW];
    logic [7:0]  mem_q;

    logic        sck_rise, sck_fall, cs_fall;
    logic [7:0]  rx_byte;
    logic [15:0] addr_inc;
    logic        mem_we;

    assign sck_rise = sck_s2 & ~sck_d;
    assign sck_fall = ~sck_s2 & sck_d;
    assign cs_fall  = cs_d & ~cs_s2;
    assign rx_byte  = {rx[6:0], mosi_s2};
    // Only the memory-index bits advance; upper address bits are carried as-is.
    assign addr_inc = (addr & ~AMASK) | ((addr + 16'd1) & AMASK);
    // SCS rise has priority, so an edge coinciding with deselect never writes.
    assign mem_we   = (state == WDATA) && !cs_s2 && sck_rise && (bit_cnt == 5'd7);

    // Synchronizers; SCS resets to the deselected level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_d   <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_d    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= spiSCK;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            cs_s1   <= spiSCS;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= spiMOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    // Memory is not reset; contents survive rstn.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[addr[MEM_AW-1:0]] <= rx_byte;
        mem_q <= mem[addr[MEM_AW-1:0]];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            spiMISO  <= 1'b0;
            selected <= 1'b0;
            wrStrobe <= 1'b0;
            bit_cnt  <= 5'd0;
            addr     <= 16'd0;
            rx       <= 8'd0;
            tx       <= 8'd0;
            ld_pipe  <= 2'b00;
            is_wr    <= 1'b0;
`ifdef STORAGE_WEL_EN
            wel      <= 1'b0;
`endif
        end else begin
            selected <= ~cs_s1;
            wrStrobe <= 1'b0;
            ld_pipe  <= {ld_pipe[0], 1'b0};
            if (ld_pipe[1])
                tx <= mem_q;

            if (state == IDLE) begin
                spiMISO <= 1'b0;
                if (cs_fall) begin
                    state   <= CMD;
                    bit_cnt <= 5'd0;
                    rx      <= 8'd0;
                end
            end else if (cs_s2) begin
                // Deselect: abandon any partial byte.
                state   <= IDLE;
                spiMISO <= 1'b0;
                bit_cnt <= 5'd0;
                ld_pipe <= 2'b00;
                is_wr   <= 1'b0;
`ifdef STORAGE_WEL_EN
                if (is_wr)
                    wel <= 1'b0;
`endif
            end else begin
                case (state)
                    CMD: if (sck_rise) begin
                        rx      <= rx_byte;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= 5'd0;
                            case (rx_byte)
                                8'h03: begin
                                    is_wr <= 1'b0;
                                    state <= ADDR;
                                end
`ifdef STORAGE_WEL_EN
                                8'h02: begin
                                    if (wel) begin
                                        is_wr <= 1'b1;
                                        state <= ADDR;
                                    end else begin
                                        state <= IGNORE;
                                    end
                                end
                                8'h06: begin
                                    wel   <= 1'b1;
                                    state <= IGNORE;
                                end
`else
                                8'h02: begin
                                    is_wr <= 1'b1;
                                    state <= ADDR;
                                end
`endif
                                default: state <= IGNORE;
                            endcase
                        end
                    end
                    ADDR: if (sck_rise) begin
                        addr    <= {addr[14:0], mosi_s2};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            bit_cnt <= 5'd0;
                            if (is_wr) begin
                                state <= WDATA;
                            end else begin
                                state   <= RDATA;
                                ld_pipe <= {ld_pipe[0], 1'b1};
                            end
                        end
                    end
                    RDATA: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= 5'd0;
                                addr    <= addr_inc;
                                ld_pipe <= {ld_pipe[0], 1'b1};
                            end
                        end else if (sck_fall) begin
                            spiMISO <= tx[7];
                            tx      <= {tx[6:0], 1'b0};
                        end
                    end
                    WDATA: if (sck_rise) begin
                        rx      <= rx_byte;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt  <= 5'd0;
                            wrStrobe <= 1'b1;
                            addr     <= addr_inc;
                        end
                    end
                    IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
